// File: rtl/sad_accum_if.sv
// sad_accum_if: sample-in and frame-result handshake bundle for sad_accum
interface sad_accum_if #(
  parameter int SIZE = 4,
  parameter int COUNT = 16
);
  localparam int CW = $clog2(COUNT);
  localparam int SW = SIZE + CW;
  logic            in_valid;
  logic            br;
  logic [SIZE-1:0] d;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_sum;
  logic [SIZE-1:0] out_max;
  logic [CW:0]     out_brw;
  modport master (
    output in_valid, br, d, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_brw
  );
  modport slave (
    input  in_valid, br, d, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_brw
  );
endinterface

// File: rtl/sad_accum.sv
// sad_accum: converts subtractor borrow/difference to magnitude and accumulates per-frame SAD, max and borrow count
module sad_accum #(
  parameter int SIZE = 4,
  parameter int COUNT = 16
) (
  input logic       clk,
  input logic       rst,
  sad_accum_if.slave bus
);
  localparam int CW = $clog2(COUNT);
  localparam int SW = SIZE + CW;
  localparam int NW = CW + 1;
  typedef enum logic {ACC, HOLD} state_t;
  state_t          state, state_nxt;
  logic [SW-1:0]   sum;
  logic [SIZE-1:0] max;
  logic [CW:0]     brw;
  logic [NW-1:0]   cnt;
  logic [SIZE-1:0] mag;
  logic            accept, done, last;
  // two's-complement negation recovers |a-b| when the subtractor borrowed
  assign mag    = bus.br ? (~bus.d + 1'b1) : bus.d;
  assign accept = bus.in_valid && state == ACC;
  assign done   = bus.out_ready && state == HOLD;
  assign last   = cnt == NW'(COUNT - 1);
  always_comb begin
    state_nxt     = state == ACC ? ((accept && last) ? HOLD : ACC) : (done ? ACC : HOLD);
    bus.in_ready  = state == ACC;
    bus.out_valid = state == HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst || done) begin
      state <= ACC;
      sum   <= '0;
      max   <= '0;
      brw   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sum <= sum + SW'(mag);
        max <= mag > max ? mag : max;
        brw <= brw + NW'(bus.br);
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign bus.out_sum = sum;
  assign bus.out_max = max;
  assign bus.out_brw = brw;
endmodule

// File: tb/tb_sad_accum.sv
// tb_sad_accum: table-driven frames plus hand-written corner sequences, scoreboard-checked
module tb_sad_accum;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int errors = 0;
  sad_accum_if #(.SIZE(4), .COUNT(16)) bus ();
  sad_accum #(.SIZE(4), .COUNT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       br;
    logic [3:0] d;
    bit         gaps;
    bit         rdy_early;
    int         sum;
    int         mx;
    int         brw;
  } vec_t;
  typedef struct {
    int sum;
    int mx;
    int brw;
  } exp_t;
  exp_t q[$];
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int magf(input logic b, input logic [3:0] dd);
    return b ? ((16 - int'(dd)) % 16) : int'(dd);
  endfunction
  task automatic send(input logic b, input logic [3:0] dd, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.in_valid = 0;
        bus.d = 4'($urandom);
      end
    end
    @(negedge clk);
    chk("in_ready_acc", bus.in_ready, 1);
    bus.in_valid = 1;
    bus.br = b;
    bus.d = dd;
    @(posedge clk);
  endtask
  task automatic collect(input string nm);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 0;
    chk({nm, "_latency"}, bus.out_valid, 1);
    chk({nm, "_in_ready_hold"}, bus.in_ready, 0);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard got empty queue expected entry", nm);
    end else begin
      e = q.pop_front();
      chk({nm, "_sum"}, bus.out_sum, e.sum);
      chk({nm, "_max"}, bus.out_max, e.mx);
      chk({nm, "_brw"}, bus.out_brw, e.brw);
    end
    bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 0;
    chk({nm, "_clr_valid"}, bus.out_valid, 0);
    chk({nm, "_clr_sum"}, bus.out_sum, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    exp_t e;
    logic b;
    logic [3:0] dd;
    logic [3:0] rd[16];
    logic rb[16];
    tbl[0] = '{1'b0, 4'd5,  1'b0, 1'b0, 80,  5,  0};
    tbl[1] = '{1'b1, 4'd13, 1'b0, 1'b0, 48,  3,  16};
    tbl[2] = '{1'b1, 4'd1,  1'b1, 1'b0, 240, 15, 16};
    tbl[3] = '{1'b0, 4'd0,  1'b0, 1'b1, 0,   0,  0};
    tbl[4] = '{1'b0, 4'd15, 1'b1, 1'b1, 240, 15, 0};
    tbl[5] = '{1'b1, 4'd0,  1'b0, 1'b0, 0,   0,  16};
    rst = 1;
    bus.in_valid = 0;
    bus.br = 0;
    bus.d = 0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_max", bus.out_max, 0);
    chk("rst_brw", bus.out_brw, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = tbl[i].rdy_early;
      q.push_back('{tbl[i].sum, tbl[i].mx, tbl[i].brw});
      for (int k = 0; k < 16; k++) send(tbl[i].br, tbl[i].d, tbl[i].gaps);
      collect($sformatf("row%0d", i));
    end
    e = '{0, 0, 0};
    for (int k = 0; k < 16; k++) begin
      rb[k] = 1'($urandom);
      rd[k] = 4'($urandom);
      e.sum += magf(rb[k], rd[k]);
      e.mx = magf(rb[k], rd[k]) > e.mx ? magf(rb[k], rd[k]) : e.mx;
      e.brw += int'(rb[k]);
    end
    q.push_back(e);
    for (int k = 0; k < 16; k++) send(rb[k], rd[k], 1'b1);
    collect("random");
    q.push_back('{48, 3, 0});
    for (int k = 0; k < 16; k++) send(1'b0, 4'd3, 1'b0);
    @(negedge clk);
    bus.in_valid = 1;
    bus.d = 4'd7;
    repeat (5) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_sum", bus.out_sum, 48);
      chk("bp_max", bus.out_max, 3);
      @(negedge clk);
    end
    e = q.pop_front();
    chk("bp_final_sum", bus.out_sum, e.sum);
    bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 0;
    bus.in_valid = 0;
    chk("bp_clr_valid", bus.out_valid, 0);
    chk("bp_no_accept_on_hs", bus.out_sum, 0);
    q.push_back('{32, 2, 0});
    for (int k = 0; k < 16; k++) send(1'b0, 4'd2, 1'b0);
    collect("bp_next");
    for (int k = 0; k < 7; k++) send(1'b0, 4'd9, 1'b0);
    @(negedge clk);
    rst = 1;
    bus.in_valid = 1;
    bus.d = 4'd9;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    bus.in_valid = 0;
    chk("midrst_sum", bus.out_sum, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    q.push_back('{16, 1, 0});
    for (int k = 0; k < 16; k++) send(1'b0, 4'd1, 1'b0);
    collect("midrst");
    for (int k = 0; k < 16; k++) send(1'b1, 4'd12, 1'b0);
    @(negedge clk);
    bus.in_valid = 0;
    chk("holdrst_pre_valid", bus.out_valid, 1);
    rst = 1;
    bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    bus.out_ready = 0;
    chk("holdrst_valid", bus.out_valid, 0);
    chk("holdrst_sum", bus.out_sum, 0);
    chk("holdrst_brw", bus.out_brw, 0);
    chk("holdrst_max", bus.out_max, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
